// File: rtl/frame_chan_sched.sv
// Round-robin scheduler sharing one byte-wide FIFO write port among NCH frame sources.
// Optional idle-byte watchdog enabled by defining FRAME_CHAN_SCHED_TIMEOUT_EN.
module frame_chan_sched #(
    parameter int NCH         = 4,
    parameter int FRAME_LEN   = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     chan_mask,
    input  logic               stop_req,
    input  logic [NCH-1:0]     req,
    output logic [NCH-1:0]     gnt,
    input  logic [8*NCH-1:0]   ch_dat,
    input  logic [NCH-1:0]     ch_en,
    input  logic               fifo_full_h,
    output logic [7:0]         dat_out,
    output logic               en_out,
    output logic [2:0]         cur_ch,
    output logic               busy,
    output logic               frame_done,
    output logic               err_stray,
    output logic               timeout
);

    // state | meaning
    // IDLE  | parked; waits for stop_req low
    // ARB   | picks next eligible channel after cur_ch once FIFO has room
    // XFER  | forwards granted channel bytes until FRAME_LEN accepted
    // GAP   | one dead cycle between frames
    typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

    localparam logic [15:0] LAST_BYTE = 16'(FRAME_LEN - 1);

    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("frame_chan_sched: NCH out of range");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 65535) begin : g_bad_len
        $error("frame_chan_sched: FRAME_LEN out of range");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_to
        $error("frame_chan_sched: TIMEOUT_CYC out of range");
    end

    state_t         state;
    logic [15:0]    cnt;
    logic [NCH-1:0] eligible;
    logic [2:0]     pick;
    logic [2:0]     pick_hi;
    logic [2:0]     pick_lo;
    logic           found_hi;
    logic           found_lo;
    logic [NCH-1:0] pick_oh;
    logic           sel_en;
    logic [7:0]     sel_dat;

    assign eligible = req & chan_mask;

    // Round-robin: lowest eligible index above cur_ch, else wrap to lowest eligible overall.
    always_comb begin
        pick_hi  = 3'd0;
        pick_lo  = 3'd0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_oh  = '0;
        sel_en   = 1'b0;
        sel_dat  = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            if (!found_hi && eligible[i] && (3'(i) > cur_ch)) begin
                pick_hi  = 3'(i);
                found_hi = 1'b1;
            end
            if (!found_lo && eligible[i]) begin
                pick_lo  = 3'(i);
                found_lo = 1'b1;
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
        for (int i = 0; i < NCH; i++) begin
            pick_oh[i] = (pick == 3'(i));
            if (cur_ch == 3'(i)) begin
                sel_en  = ch_en[i] & gnt[i];
                sel_dat = ch_dat[8*i +: 8];
            end
        end
    end

    assign busy = (state == XFER) || (state == GAP) || (|gnt);

`ifdef FRAME_CHAN_SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd      <= 16'd0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == ARB || sel_en) begin
                wd <= 16'd0;
            end else if (state == XFER) begin
                if (wd == WD_LAST) begin
                    timeout <= 1'b1;
                end else begin
                    wd <= wd + 16'd1;
                end
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            dat_out    <= 8'd0;
            en_out     <= 1'b0;
            cur_ch     <= 3'(NCH - 1);
            frame_done <= 1'b0;
            err_stray  <= 1'b0;
            cnt        <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            en_out     <= 1'b0;
            // Any byte offered without its grant is flagged and dropped.
            err_stray  <= err_stray | (|(ch_en & ~gnt));
            case (state)
                IDLE: begin
                    if (!stop_req) state <= ARB;
                end
                ARB: begin
                    if (!fifo_full_h && (|eligible)) begin
                        gnt    <= pick_oh;
                        cur_ch <= pick;
                        cnt    <= 16'd0;
                        state  <= XFER;
                    end else if (stop_req) begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    dat_out <= sel_dat;
                    en_out  <= sel_en;
                    if (sel_en) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == LAST_BYTE) begin
                            gnt        <= '0;
                            frame_done <= 1'b1;
                            state      <= GAP;
                        end
                    end
`ifdef FRAME_CHAN_SCHED_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        gnt   <= '0;
                        state <= GAP;
                    end
`endif
                end
                GAP: begin
                    state <= stop_req ? IDLE : ARB;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_chan_sched.sv
// Scoreboard bench for frame_chan_sched: driver pushes expected bytes/frames, monitor checks.
module tb_frame_chan_sched;
    localparam int NCH = 4;
    localparam int FL  = 4;
    localparam int TO  = 8;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } byte_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   chan_mask;
    logic             stop_req;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   gnt;
    logic [8*NCH-1:0] ch_dat;
    logic [NCH-1:0]   ch_en;
    logic             fifo_full_h;
    logic [7:0]       dat_out;
    logic             en_out;
    logic [2:0]       cur_ch;
    logic             busy;
    logic             frame_done;
    logic             err_stray;
    logic             timeout;

    frame_chan_sched #(.NCH(NCH), .FRAME_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .chan_mask(chan_mask), .stop_req(stop_req),
        .req(req), .gnt(gnt), .ch_dat(ch_dat), .ch_en(ch_en),
        .fifo_full_h(fifo_full_h), .dat_out(dat_out), .en_out(en_out),
        .cur_ch(cur_ch), .busy(busy), .frame_done(frame_done),
        .err_stray(err_stray), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          frame_cnt = 0;
    int          last_rise = 0;
    logic        rise_valid = 1'b0;
    logic        check_gap = 1'b0;
    logic [NCH-1:0] stream_en = '0;
    logic        stray_go = 1'b0;
    logic [NCH-1:0] prev_gnt = '0;
    logic [5:0]  seq [NCH];
    byte_t       exp_bytes [$];
    int          exp_frames [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        int b = 0;
        while (frame_cnt < n && b < 200) begin
            tick();
            b++;
        end
        chk("frame_count", frame_cnt, n);
    endtask

    task automatic wait_rise();
        int b = 0;
        while (gnt == '0 && b < 50) begin
            tick();
            b++;
        end
        chk("grant_seen", (gnt != '0), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Channel model: streams a byte every cycle while granted and enabled.
    always @(negedge clk) begin
        logic [NCH-1:0]   en_v;
        logic [8*NCH-1:0] d_v;
        en_v = '0;
        d_v  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (stream_en[i] && gnt[i]) begin
                en_v[i]         = 1'b1;
                d_v[8*i +: 8]   = {2'(i), seq[i]};
                exp_bytes.push_back('{dat: {2'(i), seq[i]}, cyc: cyc});
                seq[i]          = seq[i] + 6'd1;
            end
        end
        if (stray_go && !gnt[1]) begin
            en_v[1]    = 1'b1;
            d_v[15:8]  = 8'hEE;
        end
        ch_en  = en_v;
        ch_dat = d_v;
    end

    // Monitor
    always @(negedge clk) begin
        if (en_out) begin
            if (exp_bytes.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_byte: got dat_out=%0h, no byte expected (cycle %0d)", dat_out, cyc);
            end else begin
                byte_t e;
                e = exp_bytes.pop_front();
                chk("dat_out", dat_out, e.dat);
                chk("latency", cyc - e.cyc, 1);
            end
        end
        if (prev_gnt == '0 && gnt != '0) begin
            if (exp_frames.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_grant: got gnt=%0h, no grant expected (cycle %0d)", gnt, cyc);
            end else begin
                chk("gnt_onehot", gnt, 32'(1 << exp_frames[0]));
            end
            if (check_gap && rise_valid) chk("grant_spacing", cyc - last_rise, 6);
            last_rise  = cyc;
            rise_valid = check_gap;
        end
        if (!check_gap) rise_valid = 1'b0;
        if (frame_done) begin
            if (exp_frames.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame_done: got cur_ch=%0d, none expected (cycle %0d)", cur_ch, cyc);
            end else begin
                chk("frame_ch", cur_ch, exp_frames.pop_front());
            end
            chk("gnt_after_frame", gnt, 0);
            frame_cnt++;
        end
        prev_gnt = gnt;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish before 500us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NCH; i++) seq[i] = 6'd0;
        reset = 1'b1; chan_mask = '0; stop_req = 1'b0; req = '0;
        fifo_full_h = 1'b0; ch_en = '0; ch_dat = '0;
        repeat (3) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_en_out", en_out, 0);
        chk("rst_dat_out", dat_out, 0);
        chk("rst_cur_ch", cur_ch, NCH - 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_stray", err_stray, 0);
        chk("rst_timeout", timeout, 0);

        // Full round robin, then single eligible channel back-to-back.
        req = 4'b1111; chan_mask = 4'b1111; stream_en = 4'b1111; check_gap = 1'b1;
        exp_frames = '{0, 1, 2, 3, 0, 2, 2, 2};
        reset = 1'b0;
        wait_frames(5);
        req = 4'b0101; chan_mask = 4'b0100;
        wait_frames(8);
        check_gap = 1'b0; req = '0;
        chk("no_stray_yet", err_stray, 0);

        // FIFO almost-full holds arbitration, ignored mid-frame.
        chan_mask = 4'b1111; req = 4'b0001; fifo_full_h = 1'b1;
        repeat (5) begin
            tick();
            chk("full_holds_gnt", gnt, 0);
        end
        exp_frames.push_back(0);
        fifo_full_h = 1'b0;
        tick();
        chk("gnt_after_full_drop", gnt, 4'b0001);
        tick();
        fifo_full_h = 1'b1;
        wait_frames(9);
        req = '0; fifo_full_h = 1'b0;

        // stop_req at byte 2: frame finishes, then parks.
        req = 4'b1111;
        exp_frames.push_back(1);
        wait_rise();
        tick(); tick();
        stop_req = 1'b1;
        wait_frames(10);
        repeat (6) begin
            tick();
            chk("stop_gnt", gnt, 0);
            chk("stop_busy", busy, 0);
        end
        exp_frames.push_back(2);
        stop_req = 1'b0;
        wait_frames(11);
        req = '0;

        // Stray byte from ch1 while ch0 granted.
        req = 4'b0001;
        exp_frames.push_back(0);
        wait_rise();
        chk("err_before_stray", err_stray, 0);
        stray_go = 1'b1;
        tick();
        stray_go = 1'b0;
        chk("err_stray_set", err_stray, 1);
        wait_frames(12);
        req = '0;
        chk("err_stray_sticky", err_stray, 1);

        // Reset after two bytes of a frame.
        req = 4'b0001;
        exp_frames.push_back(0);
        wait_rise();
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_gnt", gnt, 0);
        chk("midrst_en_out", en_out, 0);
        chk("midrst_err", err_stray, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cur_ch", cur_ch, NCH - 1);
        exp_bytes.delete();
        exp_frames.delete();
        reset = 1'b0; req = '0;
        repeat (3) begin
            tick();
            chk("post_rst_en_out", en_out, 0);
        end

`ifdef FRAME_CHAN_SCHED_TIMEOUT_EN
        req = 4'b0011;
        exp_frames.push_back(0);
        wait_rise();
        tick();
        stream_en = '0;
        repeat (7) tick();
        chk("wd_not_yet", timeout, 0);
        chk("wd_gnt_held", gnt, 4'b0001);
        tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_gnt_drop", gnt, 0);
        chk("wd_no_frame_done", frame_done, 0);
        void'(exp_frames.pop_front());
        exp_frames.push_back(1);
        stream_en = 4'b1111;
        tick();
        chk("wd_pulse_end", timeout, 0);
        wait_frames(13);
        req = '0;
        repeat (4) tick();
`endif

        chk("bytes_left", exp_bytes.size(), 0);
        chk("frames_left", exp_frames.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
